// File: rtl/rc_pot_scanner.sv
// Multi-channel RC-discharge potentiometer reader: charges each pin in turn,
// releases it, and counts clock cycles until the synchronised readback drops.
module rc_pot_scanner #(
    parameter int CHANNELS     = 4,
    parameter int CNT_W        = 20,
    parameter int CHARGE_TICKS = 240000,
    parameter int DISP_BITS    = 4,
    localparam int SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int TICK_W      = (CHARGE_TICKS > 1) ? $clog2(CHARGE_TICKS) : 1
) (
    input  logic                 clki_i,
    input  logic                 resetn_i,
    input  logic                 en_i,
    input  logic [CHANNELS-1:0]  in_i,
    output logic [CHANNELS-1:0]  drive_hi_o,
    output logic                 result_valid_o,
    output logic [SEL_W-1:0]     result_ch_o,
    output logic [CNT_W-1:0]     result_o,
    output logic                 result_timeout_o,
    input  logic [SEL_W-1:0]     disp_sel_i,
    output logic [DISP_BITS-1:0] disp_o
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_CHARGING  = 2'd1;
    localparam logic [1:0] ST_MEASURING = 2'd2;
    localparam logic [1:0] ST_FINISHED  = 2'd3;

    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CHARGE_TICKS - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [SEL_W-1:0]  CH_LAST   = SEL_W'(CHANNELS - 1);
    localparam logic [SEL_W-1:0]  CH_ONE    = SEL_W'(1);

    logic [CHANNELS-1:0]  sync1_q, sync2_q;
    logic [1:0]           state_q, state_d;
    logic [SEL_W-1:0]     ch_q, ch_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 timeout_q, timeout_d;
    logic [CHANNELS-1:0]  drive_hi_q, drive_hi_d;
    logic                 result_valid_q;
    logic [SEL_W-1:0]     result_ch_q;
    logic [CNT_W-1:0]     result_q;
    logic                 result_timeout_q;
    logic [CNT_W-1:0]     stored_q [CHANNELS];
    logic [DISP_BITS-1:0] disp_q, disp_d;
    logic                 pin_s;

    always_ff @(posedge clki_i or negedge resetn_i) begin
        if (!resetn_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_i;
            sync2_q <= sync1_q;
        end
    end

    // Explicit mux keeps the select legal when CHANNELS is not a power of two.
    always_comb begin
        pin_s = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_q == SEL_W'(i)) pin_s = sync2_q[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        tick_d    = tick_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (en_i) begin
                    state_d = ST_CHARGING;
                    tick_d  = '0;
                end
            end
            ST_CHARGING: begin
                if (tick_q == TICK_LAST) begin
                    state_d   = ST_MEASURING;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                end else begin
                    tick_d = tick_q + TICK_ONE;
                end
            end
            ST_MEASURING: begin
                if (!pin_s) begin
                    state_d = ST_FINISHED;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = ST_FINISHED;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_FINISHED: begin
                ch_d    = (ch_q == CH_LAST) ? '0 : ch_q + CH_ONE;
                tick_d  = '0;
                state_d = en_i ? ST_CHARGING : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Drive is decoded from next state so the registered pin follows CHARGING exactly.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_drive
        assign drive_hi_d[gi] = (state_d == ST_CHARGING) && (ch_d == SEL_W'(gi));
    end

    always_comb begin
        disp_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (disp_sel_i == SEL_W'(i)) disp_d = stored_q[i][CNT_W-1 -: DISP_BITS];
        end
    end

    always_ff @(posedge clki_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q          <= ST_IDLE;
            ch_q             <= '0;
            tick_q           <= '0;
            cnt_q            <= '0;
            timeout_q        <= 1'b0;
            drive_hi_q       <= '0;
            result_valid_q   <= 1'b0;
            result_ch_q      <= '0;
            result_q         <= '0;
            result_timeout_q <= 1'b0;
            disp_q           <= '0;
            for (int i = 0; i < CHANNELS; i++) stored_q[i] <= '0;
        end else begin
            state_q        <= state_d;
            ch_q           <= ch_d;
            tick_q         <= tick_d;
            cnt_q          <= cnt_d;
            timeout_q      <= timeout_d;
            drive_hi_q     <= drive_hi_d;
            disp_q         <= disp_d;
            result_valid_q <= (state_q == ST_FINISHED);
            if (state_q == ST_FINISHED) begin
                result_ch_q      <= ch_q;
                result_q         <= cnt_q;
                result_timeout_q <= timeout_q;
                for (int i = 0; i < CHANNELS; i++) begin
                    if (ch_q == SEL_W'(i)) stored_q[i] <= cnt_q;
                end
            end
        end
    end

    assign drive_hi_o       = drive_hi_q;
    assign result_valid_o   = result_valid_q;
    assign result_ch_o      = result_ch_q;
    assign result_o         = result_q;
    assign result_timeout_o = result_timeout_q;
    assign disp_o           = disp_q;

endmodule

// File: tb/tb_rc_pot_scanner.sv
// Bench for rc_pot_scanner: RC pin model, table-driven and randomized measurements,
// enable-drop and mid-charge reset sequences.
module tb_rc_pot_scanner;

    localparam int CH   = 3;
    localparam int CW   = 8;
    localparam int CT   = 10;
    localparam int DB   = 4;
    localparam int SW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          en = 1'b0;
    logic [CH-1:0] in_raw;
    logic [CH-1:0] drive_w;
    logic          rv_w;
    logic [SW-1:0] rch_w;
    logic [CW-1:0] res_w;
    logic          rto_w;
    logic [SW-1:0] dsel = '0;
    logic [DB-1:0] disp_w;

    rc_pot_scanner #(
        .CHANNELS(CH), .CNT_W(CW), .CHARGE_TICKS(CT), .DISP_BITS(DB)
    ) dut (
        .clki_i(clk), .resetn_i(resetn), .en_i(en), .in_i(in_raw),
        .drive_hi_o(drive_w), .result_valid_o(rv_w), .result_ch_o(rch_w),
        .result_o(res_w), .result_timeout_o(rto_w),
        .disp_sel_i(dsel), .disp_o(disp_w)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    longint last_cyc = 0;
    int     stored_m [CH];

    // Pin model: the node charges while driven, then reads high for rel cycles after release.
    int rel [CH];
    bit tied [CH];
    bit hold [CH];
    bit charged [CH];
    int mcnt [CH];

    always @(posedge clk) begin
        #1;
        for (int c = 0; c < CH; c++) begin
            if (drive_w[c]) begin
                charged[c] = 1'b1;
                mcnt[c]    = 0;
            end else if (charged[c] && !hold[c]) begin
                if (mcnt[c] >= rel[c]) charged[c] = 1'b0;
                else mcnt[c]++;
            end
        end
    end

    always_comb begin
        in_raw = '0;
        for (int c = 0; c < CH; c++) in_raw[c] = charged[c] & ~tied[c];
    end

    typedef struct {int ch; int res; bit to; longint cyc;} obs_t;
    obs_t got[$];
    int   run [CH];

    always @(negedge clk) begin
        cyc++;
        if (rv_w) got.push_back('{ch: int'(rch_w), res: int'(res_w), to: rto_w, cyc: cyc});
        checks++;
        if ($countones(drive_w) > 1) begin
            errors++;
            $display("FAIL drive_onehot: got %b required at most one bit", drive_w);
        end
        for (int c = 0; c < CH; c++) begin
            if (!resetn) run[c] = 0;
            else if (drive_w[c]) run[c]++;
            else if (run[c] != 0) begin
                checks++;
                if (run[c] != CT) begin
                    errors++;
                    $display("FAIL drive_len ch%0d: got %0d cycles required %0d", c, run[c], CT);
                end
                run[c] = 0;
            end
        end
    end

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic finish_now();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic wait_result(output obs_t o);
        int n = 0;
        while (got.size() == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (got.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL strobe_wait: got no strobe in %0d cycles required one", n);
            finish_now();
        end
        o = got.pop_front();
    endtask

    // Spec-level expectation: release at measuring cycle r reports r+2, saturating at CMAX.
    function automatic void model(input bit t, input bit h, input int r, output int v, output bit to);
        if (t) begin v = 0; to = 1'b0; end
        else if (h || (r + 2 > CMAX)) begin v = CMAX; to = 1'b1; end
        else begin v = r + 2; to = 1'b0; end
    endfunction

    task automatic expect_result(input int ch, input int v, input bit to, input bit chk_period);
        obs_t o;
        wait_result(o);
        $display("result ch=%0d count=%0d timeout=%0d cycle=%0d", o.ch, o.res, o.to, o.cyc);
        check("result_ch", o.ch, ch);
        check("result", o.res, v);
        check("result_timeout", o.to, to);
        if (chk_period) check("strobe_period", o.cyc - last_cyc, CT + v + 2);
        last_cyc     = o.cyc;
        stored_m[ch] = v;
    endtask

    task automatic check_disp();
        int last_res;
        last_res = int'(res_w);
        for (int s = 0; s < 4; s++) begin
            dsel = SW'(s);
            @(negedge clk);
            check("disp", disp_w, (s < CH) ? (stored_m[s] >> (CW - DB)) : 0);
        end
        check("result_hold", res_w, last_res);
    endtask

    typedef struct {int rel; bit tied; bit hold; int exp_res; bit exp_to;} vec_t;
    vec_t tbl [12];

    initial begin
        int v;
        bit to;
        int idle_drive;
        tbl[0]  = '{1,   0, 0, 3,   0};
        tbl[1]  = '{4,   0, 0, 6,   0};
        tbl[2]  = '{9,   0, 0, 11,  0};
        tbl[3]  = '{0,   0, 1, 255, 1};
        tbl[4]  = '{5,   0, 0, 7,   0};
        tbl[5]  = '{0,   1, 0, 0,   0};
        tbl[6]  = '{0,   1, 0, 0,   0};
        tbl[7]  = '{0,   1, 0, 0,   0};
        tbl[8]  = '{0,   1, 0, 0,   0};
        tbl[9]  = '{0,   0, 0, 2,   0};
        tbl[10] = '{253, 0, 0, 255, 0};
        tbl[11] = '{254, 0, 0, 255, 1};
        for (int c = 0; c < CH; c++) begin
            rel[c] = 0; tied[c] = 1'b0; hold[c] = 1'b0;
            charged[c] = 1'b0; mcnt[c] = 0; run[c] = 0; stored_m[c] = 0;
        end

        // Reset held with enable asserted.
        en = 1'b1;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_drive_hi", drive_w, 0);
        check("rst_result_valid", rv_w, 0);
        check("rst_result", res_w, 0);
        check("rst_result_ch", rch_w, 0);
        check("rst_result_timeout", rto_w, 0);
        check("rst_disp", disp_w, 0);

        for (int c = 0; c < CH; c++) begin
            rel[c] = tbl[c].rel; tied[c] = tbl[c].tied; hold[c] = tbl[c].hold;
        end
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("first_charge_drive", drive_w, 3'b001);

        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < CH; c++) begin
                rel[c] = tbl[3*r+c].rel; tied[c] = tbl[3*r+c].tied; hold[c] = tbl[3*r+c].hold;
            end
            for (int c = 0; c < CH; c++)
                expect_result(c, tbl[3*r+c].exp_res, tbl[3*r+c].exp_to, !(r == 0 && c == 0));
            check_disp();
        end

        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < CH; c++) begin
                tied[c] = ($urandom % 8) == 0;
                hold[c] = !tied[c] && (($urandom % 8) == 0);
                rel[c]  = $urandom_range(0, 260);
            end
            for (int c = 0; c < CH; c++) begin
                model(tied[c], hold[c], rel[c], v, to);
                expect_result(c, v, to, 1'b1);
            end
            check_disp();
        end

        // Enable dropped while channel 1 is measuring.
        rel[0] = 3; rel[1] = 20; rel[2] = 7;
        for (int c = 0; c < CH; c++) begin tied[c] = 1'b0; hold[c] = 1'b0; end
        expect_result(0, 5, 1'b0, 1'b1);
        repeat (CT + 6) @(negedge clk);
        en = 1'b0;
        expect_result(1, 22, 1'b0, 1'b1);
        idle_drive = 0;
        repeat (30) begin
            @(negedge clk);
            if (drive_w != 0) idle_drive++;
        end
        check("idle_no_strobe", got.size(), 0);
        check("idle_drive_cycles", idle_drive, 0);
        en = 1'b1;
        @(negedge clk);
        check("resume_drive_ch2", drive_w, 3'b100);
        expect_result(2, 9, 1'b0, 1'b0);

        // Reset asserted mid-charge on channel 0.
        @(negedge clk);
        check("charging_before_rst", drive_w, 3'b001);
        #2 resetn = 1'b0;
        #1 check("async_drive_release", drive_w, 0);
        repeat (2) @(negedge clk);
        dsel = '0;
        check("rst2_result_valid", rv_w, 0);
        check("rst2_result", res_w, 0);
        check("rst2_result_ch", rch_w, 0);
        check("rst2_disp", disp_w, 0);
        got.delete();
        en = 1'b0;
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_no_strobe", got.size(), 0);
        check("post_rst_drive", drive_w, 0);

        finish_now();
    end

endmodule
